// File: rtl/placar_acumulador.sv
// Scoreboard front end: syncs and debounces three buttons and keeps a saturating 7-bit score.
// Latency: btn rise first sampled at edge E is visible on o_pontos after edge E+DEBOUNCE_CYCLES+3.
module placar_acumulador #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int MAX_SCORE       = 99,
    parameter int PTS0            = 1,
    parameter int PTS1            = 2,
    parameter int PTS2            = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_btn,
    input  logic       i_sinal,
    input  logic       i_ch,
    input  logic       i_carregar,
    input  logic [6:0] i_chave,
    output logic [6:0] o_pontos,
    output logic       o_atualizado,
    output logic       o_saturou
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]       MAX7     = 7'(MAX_SCORE);

    logic [5:0] w_async;
    logic [5:0] r_sync1;
    logic [5:0] r_sync2;
    logic [2:0] w_btn_s;
    logic       w_sinal_s;
    logic       w_ch_s;
    logic       w_carr_s;

    assign w_async = {i_carregar, i_ch, i_sinal, i_btn};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_async;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s   = r_sync2[2:0];
    assign w_sinal_s = r_sync2[3];
    assign w_ch_s    = r_sync2[4];
    assign w_carr_s  = r_sync2[5];

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    logic [2:0] w_est;
    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic [CNT_W-1:0] r_cnt;
        logic             r_est;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_cnt <= '0;
                r_est <= 1'b0;
            end else if (w_btn_s[g] == r_est) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_est <= w_btn_s[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_est[g] = r_est;
    end

    logic [2:0] r_est_d;
    logic [2:0] r_press;
    logic       r_ch_d;
    logic       r_carr_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_est_d  <= '0;
            r_press  <= '0;
            r_ch_d   <= 1'b0;
            r_carr_d <= 1'b0;
        end else begin
            r_est_d  <= w_est;
            r_press  <= w_est & ~r_est_d;
            r_ch_d   <= w_ch_s;
            r_carr_d <= w_carr_s;
        end
    end

    logic [7:0] w_delta;
    logic [7:0] w_sum;
    logic [6:0] w_next;
    logic       w_wr;
    logic       w_sat;
    logic [6:0] r_pontos;
    logic       r_atualizado;
    logic       r_saturou;

    always_comb begin
        w_delta = '0;
        if (r_press[0]) w_delta = w_delta + 8'(PTS0);
        if (r_press[1]) w_delta = w_delta + 8'(PTS1);
        if (r_press[2]) w_delta = w_delta + 8'(PTS2);
    end

    // 8-bit sum so an add near the top cannot wrap before the clip test.
    assign w_sum = {1'b0, r_pontos} + w_delta;

    always_comb begin
        w_next = r_pontos;
        w_wr   = 1'b0;
        w_sat  = 1'b0;
        if (w_ch_s) begin
            w_next = MAX7;
            w_wr   = ~r_ch_d;
        end else if (w_carr_s && !r_carr_d) begin
            w_wr = 1'b1;
            if (i_chave > MAX7) begin
                w_next = MAX7;
                w_sat  = 1'b1;
            end else begin
                w_next = i_chave;
            end
        end else if (|r_press) begin
            w_wr = 1'b1;
            if (!w_sinal_s) begin
                if (w_sum > {1'b0, MAX7}) begin
                    w_next = MAX7;
                    w_sat  = 1'b1;
                end else begin
                    w_next = w_sum[6:0];
                end
            end else begin
                if (w_delta > {1'b0, r_pontos}) begin
                    w_next = '0;
                    w_sat  = 1'b1;
                end else begin
                    w_next = r_pontos - w_delta[6:0];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pontos     <= '0;
            r_atualizado <= 1'b0;
            r_saturou    <= 1'b0;
        end else begin
            r_pontos     <= w_next;
            r_atualizado <= w_wr;
            r_saturou    <= w_sat;
        end
    end

    assign o_pontos     = r_pontos;
    assign o_atualizado = r_atualizado;
    assign o_saturou    = r_saturou;

endmodule

// File: tb/tb_placar_acumulador.sv
// Bench for placar_acumulador: directed scenarios against fixed values, then random traffic against a history-window model.
module tb_placar_acumulador;
    localparam int D    = 4;
    localparam int MAXS = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       sinal;
    logic       ch;
    logic       carregar;
    logic [6:0] chave;
    logic [6:0] o_pontos;
    logic       o_atualizado;
    logic       o_saturou;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    placar_acumulador #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_btn(btn),
        .i_sinal(sinal),
        .i_ch(ch),
        .i_carregar(carregar),
        .i_chave(chave),
        .o_pontos(o_pontos),
        .o_atualizado(o_atualizado),
        .o_saturou(o_saturou)
    );

    // Reference: inputs are kept as per-edge sample histories; a level is accepted once the
    // D samples seen through the two-flop delay all disagree with it; a press acts two edges later.
    int         m_pontos;
    bit         m_atu;
    bit         m_sat;
    logic [2:0] hb [0:D+1];
    logic       hs [0:3];
    logic       hc [0:3];
    logic       hl [0:3];
    logic [2:0] he [0:3];
    logic [2:0] m_press;
    int         m_delta;
    int         m_t;
    bit         m_flip;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= D + 1; j++) hb[j] = '0;
            for (int j = 0; j < 4; j++) begin
                hs[j] = 1'b0; hc[j] = 1'b0; hl[j] = 1'b0; he[j] = '0;
            end
            m_pontos = 0;
            m_atu    = 1'b0;
            m_sat    = 1'b0;
        end else begin
            for (int j = D + 1; j > 0; j--) hb[j] = hb[j-1];
            hb[0] = btn;
            for (int j = 3; j > 0; j--) begin
                hs[j] = hs[j-1]; hc[j] = hc[j-1]; hl[j] = hl[j-1]; he[j] = he[j-1];
            end
            hs[0] = sinal; hc[0] = ch; hl[0] = carregar;
            he[0] = he[1];
            for (int g = 0; g < 3; g++) begin
                m_flip = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (hb[j][g] == he[1][g]) m_flip = 1'b0;
                if (m_flip) he[0][g] = ~he[1][g];
            end
            m_press = he[2] & ~he[3];
            m_delta = (m_press[0] ? 1 : 0) + (m_press[1] ? 2 : 0) + (m_press[2] ? 3 : 0);
            m_atu = 1'b0;
            m_sat = 1'b0;
            if (hc[2]) begin
                m_pontos = MAXS;
                m_atu    = hc[2] & ~hc[3];
            end else if (hl[2] && !hl[3]) begin
                m_atu = 1'b1;
                if (int'(chave) > MAXS) begin
                    m_pontos = MAXS;
                    m_sat    = 1'b1;
                end else begin
                    m_pontos = int'(chave);
                end
            end else if (m_delta != 0) begin
                m_atu = 1'b1;
                m_t   = hs[2] ? m_pontos - m_delta : m_pontos + m_delta;
                if (m_t > MAXS) begin
                    m_pontos = MAXS; m_sat = 1'b1;
                end else if (m_t < 0) begin
                    m_pontos = 0; m_sat = 1'b1;
                end else begin
                    m_pontos = m_t;
                end
            end
        end
    end

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; btn = 3'b001;
        repeat (3) @(negedge clk);
        checks++; if (o_pontos !== 7'd0) begin errors++; $display("FAIL reset_pontos got %0d want 0", o_pontos); end
        checks++; if (o_atualizado !== 1'b0) begin errors++; $display("FAIL reset_atualizado got %b want 0", o_atualizado); end
        checks++; if (o_saturou !== 1'b0) begin errors++; $display("FAIL reset_saturou got %b want 0", o_saturou); end
        rst = 1'b0; btn = 3'b000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_atualizado) pulses++;
        end
        checks++; if (o_pontos !== 7'd0) begin errors++; $display("FAIL reset_btn_pontos got %0d want 0", o_pontos); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL reset_btn_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_single_press();
        int pulses = 0;
        int exp_p;
        sinal = 1'b0; btn = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            exp_p = (i >= 8) ? 2 : 0;
            checks++;
            if (o_pontos !== 7'(exp_p)) begin errors++; $display("FAIL press_latency cycle %0d got %0d want %0d", i, o_pontos, exp_p); end
            if (i == 8) begin
                checks++; if (o_atualizado !== 1'b1) begin errors++; $display("FAIL press_atualizado got %b want 1", o_atualizado); end
            end
            if (o_atualizado) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulses got %0d want 1", pulses); end
        btn = 3'b000;
        repeat (10) @(negedge clk);
        checks++; if (o_pontos !== 7'd2) begin errors++; $display("FAIL release_pontos got %0d want 2", o_pontos); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn[0] = (i < 4) ? ~i[0] : 1'b1;
            @(negedge clk);
            if (o_atualizado) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
        checks++; if (o_pontos !== 7'd3) begin errors++; $display("FAIL bounce_pontos got %0d want 3", o_pontos); end
        btn = 3'b000;
        repeat (10) @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            btn[0] = (i < 3);
            @(negedge clk);
            if (o_atualizado) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
        checks++; if (o_pontos !== 7'd3) begin errors++; $display("FAIL glitch_pontos got %0d want 3", o_pontos); end
    endtask

    task automatic test_load_saturate();
        chave = 7'd97; carregar = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++; if (o_pontos !== 7'd97 || o_atualizado !== 1'b1 || o_saturou !== 1'b0) begin
                    errors++; $display("FAIL load97 got p=%0d a=%b s=%b want p=97 a=1 s=0", o_pontos, o_atualizado, o_saturou); end
            end
        end
        carregar = 1'b0;
        repeat (4) @(negedge clk);
        btn = 3'b100;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++; if (o_pontos !== 7'd99 || o_saturou !== 1'b1 || o_atualizado !== 1'b1) begin
                    errors++; $display("FAIL add_clip got p=%0d a=%b s=%b want p=99 a=1 s=1", o_pontos, o_atualizado, o_saturou); end
            end
        end
        btn = 3'b000;
        repeat (10) @(negedge clk);
        sinal = 1'b1;
        repeat (4) @(negedge clk);
        btn = 3'b100;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++; if (o_pontos !== 7'd96 || o_saturou !== 1'b0 || o_atualizado !== 1'b1) begin
                    errors++; $display("FAIL sub3 got p=%0d a=%b s=%b want p=96 a=1 s=0", o_pontos, o_atualizado, o_saturou); end
            end
        end
        btn = 3'b000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_subtract_clip();
        chave = 7'd2; carregar = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++; if (o_pontos !== 7'd2) begin errors++; $display("FAIL load2 got %0d want 2", o_pontos); end
            end
        end
        carregar = 1'b0;
        repeat (4) @(negedge clk);
        btn = 3'b101;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 8) begin
                checks++; if (o_pontos !== 7'd0 || o_saturou !== 1'b1 || o_atualizado !== 1'b1) begin
                    errors++; $display("FAIL sub_clip got p=%0d a=%b s=%b want p=0 a=1 s=1", o_pontos, o_atualizado, o_saturou); end
            end
        end
        btn = 3'b000;
        repeat (10) @(negedge clk);
        chave = 7'd120; carregar = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++; if (o_pontos !== 7'd99 || o_saturou !== 1'b1 || o_atualizado !== 1'b1) begin
                    errors++; $display("FAIL load120 got p=%0d a=%b s=%b want p=99 a=1 s=1", o_pontos, o_atualizado, o_saturou); end
            end
        end
        carregar = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_force_and_reset();
        int pulses = 0;
        chave = 7'd10; carregar = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 3) begin
                checks++; if (o_pontos !== 7'd10) begin errors++; $display("FAIL load10 got %0d want 10", o_pontos); end
            end
        end
        carregar = 1'b0;
        repeat (4) @(negedge clk);
        ch = 1'b1; btn = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (o_atualizado) pulses++;
            if (i == 3) begin
                checks++; if (o_pontos !== 7'd99) begin errors++; $display("FAIL force_max got %0d want 99", o_pontos); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL force_pulses got %0d want 1", pulses); end
        checks++; if (o_pontos !== 7'd99) begin errors++; $display("FAIL force_hold got %0d want 99", o_pontos); end
        btn = 3'b000;
        repeat (10) @(negedge clk);
        ch = 1'b0; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_atualizado) pulses++;
        end
        checks++; if (pulses != 0 || o_pontos !== 7'd99) begin
            errors++; $display("FAIL force_release got p=%0d pulses=%0d want p=99 pulses=0", o_pontos, pulses); end
        btn = 3'b001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; btn = 3'b000;
        checks++; if (o_pontos !== 7'd0) begin errors++; $display("FAIL midreset_pontos got %0d want 0", o_pontos); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_atualizado) pulses++;
        end
        checks++; if (pulses != 0 || o_pontos !== 7'd0) begin
            errors++; $display("FAIL midreset_later got p=%0d pulses=%0d want p=0 pulses=0", o_pontos, pulses); end
    endtask

    task automatic test_random(input int n);
        int hold [3];
        int ch_hold = 0;
        int ld_hold = 0;
        for (int g = 0; g < 3; g++) hold[g] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++; if (o_pontos !== 7'(m_pontos)) begin errors++; $display("FAIL rand_pontos cycle %0d got %0d want %0d", i, o_pontos, m_pontos); end
            checks++; if (o_atualizado !== m_atu) begin errors++; $display("FAIL rand_atualizado cycle %0d got %b want %b", i, o_atualizado, m_atu); end
            checks++; if (o_saturou !== m_sat) begin errors++; $display("FAIL rand_saturou cycle %0d got %b want %b", i, o_saturou, m_sat); end
            for (int g = 0; g < 3; g++) begin
                if (hold[g] == 0) begin
                    btn[g]  = 1'($urandom_range(0, 1));
                    hold[g] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 10));
                end else begin
                    hold[g]--;
                end
            end
            if ($urandom_range(0, 31) == 0) sinal = ~sinal;
            if (ch_hold > 0) begin
                ch = 1'b1; ch_hold--;
            end else begin
                ch = 1'b0;
                if ($urandom_range(0, 199) == 0) ch_hold = int'($urandom_range(3, 12));
            end
            if (ld_hold > 0) begin
                carregar = 1'b1; ld_hold--;
            end else begin
                carregar = 1'b0;
                if ($urandom_range(0, 7) == 0) chave = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 59) == 0) ld_hold = int'($urandom_range(1, 3));
            end
            rst = ($urandom_range(0, 799) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = 3'b000; sinal = 1'b0; ch = 1'b0; carregar = 1'b0; chave = 7'd0;
        test_reset();
        test_single_press();
        test_bounce();
        test_load_saturate();
        test_subtract_clip();
        test_force_and_reset();
        test_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/placar_acumulador.md
Name: placar_acumulador

Overview:
- Upstream stage of the scoreboard display path.
- Synchronises and debounces the three raw push-buttons and turns each press into a point value.
- Accumulates a registered 7-bit binary score, saturating at 0..MAX_SCORE.
- Drives the binary score into the existing binary-to-BCD / 7-segment path, replacing the combinational button-plus-switch sum with a persistent score.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a button level is accepted (10 ms at 50 MHz); minimum 2.
- CNT_W, 19, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- MAX_SCORE, 99, upper saturation bound; must be ≤ 127.
- PTS0, 1, points for btn[0].
- PTS1, 2, points for btn[1].
- PTS2, 3, points for btn[2].

Ports:
- clk  input  1  board clock; all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn  input  3  raw push-buttons, asynchronous, pressed = 1 after board inversion.
- sinal  input  1  0 = add button points, 1 = subtract; level, sampled through a 2-flop synchroniser.
- ch  input  1  force score to MAX_SCORE while high; synchronised.
- carregar  input  1  load chave into score; rising edge of the synchronised level.
- chave  input  7  binary load value; quasi-static, sampled when the carregar edge is detected.
- pontos  output  7  registered binary score.
- atualizado  output  1  one-cycle pulse on any cycle pontos is written.
- saturou  output  1  one-cycle pulse when an add/load clipped at MAX_SCORE or a subtract clipped at 0.

Behaviour:
- Reset (rst=1 at an edge):
  - pontos, atualizado, saturou = 0.
  - Synchroniser flops, debounced levels and edge-detect flops = 0; debounce counters = 0.
  - Reset has priority over everything. Reset mid-debounce discards the pending press.
- Synchroniser: two flops per async input (btn[2:0], sinal, ch, carregar).
- Debounce, per button:
  - Keep an accepted level `est` and a counter.
  - If the synchronised level equals est, the counter clears.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1 while the level still differs, est takes the new level at that edge and the counter clears.
  - A bounce back to est before then clears the counter.
- Press event: registered one-cycle pulse when est goes 0→1. Release generates nothing.
- Latency: a clean btn rise first sampled at edge E updates pontos at edge E+DEBOUNCE_CYCLES+3. atualizado is high in the same cycle pontos shows the new value.
- Update priority per cycle, highest first:
  - ch_sync = 1: pontos := MAX_SCORE. atualizado pulses only on the cycle ch_sync rises. Presses and loads are ignored while ch_sync = 1.
  - carregar edge: pontos := min(chave, MAX_SCORE). saturou = 1 if chave > MAX_SCORE. Presses in the same cycle are dropped.
  - Press events:
    - delta = sum of PTSi over all buttons pressing this cycle (max 6).
    - sinal_sync = 0: pontos := min(pontos+delta, MAX_SCORE).
    - sinal_sync = 1: pontos := max(pontos-delta, 0).
    - Arithmetic is done at 8 bits, so no wrap.
  - Otherwise pontos holds and both pulses are 0.
- saturou is asserted only when clipping actually changed the result. Adding at exactly MAX_SCORE with delta > 0 sets saturou. A write is performed and atualizado pulses even if the value is unchanged.
- Holding a button generates exactly one event; the next event needs a debounced release and then a debounced press.
- sinal changes take effect for events on the cycle after the synchronised value changes; in-flight debounce is unaffected.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, defaults otherwise.
1. Reset, then rst=1 held 3 cycles → pontos=0, atualizado=0, saturou=0. A btn[0] pulse during reset yields no event after release.
2. btn[1] clean rise held 20 cycles, sinal=0 → pontos=2 exactly 7 edges after first sample, atualizado one pulse, no second increment while held.
3. btn[0] bouncing 1,0,1,0 each 1 cycle then stable 1 → a single +1; 3-cycle glitch → no change.
4. Load chave=97, then btn[2] press → pontos=99, saturou=1 on that cycle. Then sinal=1, btn[2] press → 96.
5. pontos=2, sinal=1, btn[0] and btn[2] accepted in the same cycle → pontos=0, saturou=1. Load chave=120 → pontos=99, saturou=1.
6. ch=1 while btn[1] press matures → pontos=99, one atualizado pulse, press ignored. ch=0, then rst=1 mid-debounce of btn[0] → pontos=0, no later increment.
